// File: rtl/ahb_wishbone_bridge.sv
// AHB-Lite responder that turns one AHB transfer at a time into one classic Wishbone access,
// stretching the data phase until ack and signalling ERROR on illegal transfers or timeout.
module ahb_wishbone_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [31:0]           hwdata,
  output logic                  hready,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [3:0]            wb_sel,
  output logic [31:0]           wb_data_out,
  input  logic [31:0]           wb_data_in,
  input  logic                  wb_ack
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StWait, StDone, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdata_q, wdata_d;

  logic accept, illegal;
  logic [3:0] sel_calc;
  logic unused_htrans;

  // BUSY and IDLE differ only in htrans[0]; both get a zero-wait OKAY.
  assign unused_htrans = htrans[0];

  assign hrdata      = hrdata_q;
  assign wb_cyc      = cyc_q;
  assign wb_stb      = cyc_q;
  assign wb_we       = we_q;
  assign wb_addr     = wb_addr_q;
  assign wb_sel      = sel_q;
  assign wb_data_out = wdata_q;

  assign accept  = hready & htrans[1];
  assign illegal = (hsize > 3'd2) ||
                   ((hsize == 3'd1) && haddr[0]) ||
                   ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  always_comb begin
    sel_calc = 4'b1111;
    unique case (size_q)
      2'd0:    sel_calc = 4'b0001 << addr_q[1:0];
      2'd1:    sel_calc = addr_q[1] ? 4'b1100 : 4'b0011;
      default: sel_calc = 4'b1111;
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    unique case (state_q)
      StSetup, StWait: hready = 1'b0;
      StErr1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      StErr2:  hresp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    hrdata_d  = hrdata_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    wb_addr_d = wb_addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      StIdle, StDone, StErr2: begin
        if (accept) begin
          addr_d  = haddr;
          write_d = hwrite;
          size_d  = hsize[1:0];
          state_d = illegal ? StErr1 : StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      StSetup: begin
        cyc_d     = 1'b1;
        we_d      = write_q;
        wb_addr_d = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        sel_d     = sel_calc;
        wdata_d   = hwdata;
        cnt_d     = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (wb_ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          if (!write_q) hrdata_d = wb_data_in;
          state_d = StDone;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntMax)) begin
          cyc_d   = 1'b0;
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      cnt_q     <= '0;
      hrdata_q  <= 32'h0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      wb_addr_q <= '0;
      sel_q     <= 4'h0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      hrdata_q  <= hrdata_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      wb_addr_q <= wb_addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_wishbone_bridge.sv
// Directed bench for ahb_wishbone_bridge: drives AHB transfers, models a Wishbone slave and
// checks completions against a scoreboard of expected responses.
module tb_ahb_wishbone_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr = 32'h0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = 32'h0;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_data_out;
  logic [31:0] wb_data_in = 32'h0;
  logic        wb_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata = 32'h0;

  ahb_wishbone_bridge #(
    .TIMEOUT_CYCLES(8),
    .ADDR_WIDTH    (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .htrans     (htrans),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready     (hready),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_sel     (wb_sel),
    .wb_data_out(wb_data_out),
    .wb_data_in (wb_data_in),
    .wb_ack     (wb_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_hresp"}, {31'd0, hresp}, {31'd0, e.resp});
      chk({tag, "_hrdata"}, hrdata, e.rdata);
    end
  endtask

  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] rd,
                      input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                      input int exp_low);
    exp_t e;
    int   low = 0;
    int   n = 0;
    bit   seen = 0;
    bit   done_ok = 0;
    chk({tag, "_accept_rdy"}, {31'd0, hready}, 32'd1);
    haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
    e.resp = 1'b0;
    e.rdata = w ? model_rdata : rd;
    if (!w) model_rdata = rd;
    sb.push_back(e);
    cycle();
    htrans = 2'b00;
    hwdata = wd;
    for (int i = 0; i < 40 && !done_ok; i++) begin
      if (hready) begin
        done_ok = 1;
      end else begin
        low++;
        if (wb_cyc && !seen) begin
          seen = 1;
          chk({tag, "_wb_stb"}, {31'd0, wb_stb}, 32'd1);
          chk({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, w});
          chk({tag, "_wb_addr"}, wb_addr, exp_addr);
          chk({tag, "_wb_sel"}, {28'd0, wb_sel}, {28'd0, exp_sel});
          chk({tag, "_wb_data_out"}, wb_data_out, wd);
        end
        if (wb_cyc) begin
          wb_ack = (n == waits);
          wb_data_in = (n == waits) ? rd : $urandom;
          n++;
        end else begin
          wb_ack = 1'b0;
        end
        cycle();
      end
    end
    wb_ack = 1'b0;
    chk({tag, "_completed"}, {31'd0, done_ok}, 32'd1);
    chk({tag, "_hready_low"}, low, exp_low);
    chk({tag, "_cyc_dropped"}, {31'd0, wb_cyc}, 32'd0);
    pop_check(tag);
  endtask

  task automatic xfer_err(input string tag, input logic [31:0] a, input logic [2:0] sz);
    exp_t e;
    chk({tag, "_accept_rdy"}, {31'd0, hready}, 32'd1);
    haddr = a; hwrite = 1'b0; hsize = sz; htrans = 2'b10;
    e.resp = 1'b1;
    e.rdata = model_rdata;
    sb.push_back(e);
    cycle();
    htrans = 2'b00;
    chk({tag, "_err1_hready"}, {31'd0, hready}, 32'd0);
    chk({tag, "_err1_hresp"}, {31'd0, hresp}, 32'd1);
    chk({tag, "_no_cyc"}, {31'd0, wb_cyc}, 32'd0);
    cycle();
    chk({tag, "_err2_hready"}, {31'd0, hready}, 32'd1);
    pop_check(tag);
    cycle();
    chk({tag, "_idle_hready"}, {31'd0, hready}, 32'd1);
    chk({tag, "_idle_hresp"}, {31'd0, hresp}, 32'd0);
  endtask

  task automatic idle_cycle();
    htrans = 2'b00;
    cycle();
    chk("idle_hready", {31'd0, hready}, 32'd1);
    chk("idle_hresp", {31'd0, hresp}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   cyc_cnt;
    bit   err_seen;

    cycle();
    cycle();
    chk("rst_hready", {31'd0, hready}, 32'd1);
    chk("rst_hresp", {31'd0, hresp}, 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_wb_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_addr", wb_addr, 32'h0);
    chk("rst_wb_sel", {28'd0, wb_sel}, 32'h0);
    chk("rst_wb_data_out", wb_data_out, 32'h0);
    rst = 1'b0;
    idle_cycle();

    xfer("word_rd", 32'h40, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 0, 32'h40, 4'hF, 2);
    idle_cycle();
    xfer("byte_wr", 32'h103, 1'b1, 3'd0, 32'hAB000000, 32'h0, 0, 32'h100, 4'b1000, 2);
    idle_cycle();
    xfer("byte_rd", 32'h2, 1'b0, 3'd0, 32'h0, 32'h00770000, 0, 32'h0, 4'b0100, 2);
    idle_cycle();

    // Second address presented while the first is in DONE.
    xfer("b2b_rd", 32'h200, 1'b0, 3'd2, 32'h0, 32'h12345678, 3, 32'h200, 4'hF, 5);
    xfer("b2b_wr", 32'h206, 1'b1, 3'd1, 32'h5A5A0000, 32'h0, 3, 32'h204, 4'b1100, 5);
    idle_cycle();

    xfer_err("misaligned_word", 32'h42, 3'd2);
    xfer_err("misaligned_half", 32'h41, 3'd1);
    xfer_err("size_too_big", 32'h40, 3'd3);

    // Slave never acks: eight wait cycles, then ERROR; a late ack must be ignored.
    haddr = 32'h300; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    e.resp = 1'b1;
    e.rdata = model_rdata;
    sb.push_back(e);
    cycle();
    htrans = 2'b00;
    hwdata = 32'h01020304;
    cyc_cnt = 0;
    err_seen = 0;
    for (int i = 0; i < 40 && !err_seen; i++) begin
      if (hresp) begin
        err_seen = 1;
      end else begin
        if (wb_cyc) cyc_cnt++;
        cycle();
      end
    end
    chk("to_err_seen", {31'd0, err_seen}, 32'd1);
    chk("to_cyc_cycles", cyc_cnt, 32'd8);
    chk("to_err1_hready", {31'd0, hready}, 32'd0);
    chk("to_err1_cyc", {31'd0, wb_cyc}, 32'd0);
    wb_ack = 1'b1;
    wb_data_in = 32'h99999999;
    cycle();
    chk("to_err2_hready", {31'd0, hready}, 32'd1);
    pop_check("to");
    cycle();
    chk("to_late_ack_hready", {31'd0, hready}, 32'd1);
    chk("to_late_ack_hresp", {31'd0, hresp}, 32'd0);
    chk("to_late_ack_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("to_late_ack_hrdata", hrdata, model_rdata);
    wb_ack = 1'b0;
    idle_cycle();

    // Reset while waiting, with an ack arriving at the same edge.
    haddr = 32'h80; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10;
    cycle();
    htrans = 2'b00;
    cycle();
    chk("rstw_cyc_high", {31'd0, wb_cyc}, 32'd1);
    cycle();
    rst = 1'b1;
    wb_ack = 1'b1;
    wb_data_in = 32'h11111111;
    cycle();
    chk("rstw_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rstw_hready", {31'd0, hready}, 32'd1);
    chk("rstw_hresp", {31'd0, hresp}, 32'd0);
    chk("rstw_hrdata", hrdata, 32'h0);
    rst = 1'b0;
    wb_ack = 1'b0;
    model_rdata = 32'h0;
    idle_cycle();
    xfer("post_rst_rd", 32'h80, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 1, 32'h80, 4'hF, 3);
    idle_cycle();

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
